// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
//   Handshake bundle between the pipeline/MDU and the stall/flush sequencer.
//
//   Requests into the sequencer : hz_stall, branch_taken_D, mdu_op_E, mdu_done
//   Controls out of it          : mdu_start, mdu_abort, StallF, StallD, StallE,
//                                 FlushD, FlushE, FlushM, redirect_D
//
//   master : pipeline / MDU side (drives requests, consumes controls)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;
    logic hz_stall;
    logic branch_taken_D;
    logic mdu_op_E;
    logic mdu_done;

    logic mdu_start;
    logic mdu_abort;
    logic StallF;
    logic StallD;
    logic StallE;
    logic FlushD;
    logic FlushE;
    logic FlushM;
    logic redirect_D;

    modport master (
        output hz_stall, branch_taken_D, mdu_op_E, mdu_done,
        input  mdu_start, mdu_abort, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, redirect_D
    );

    modport slave (
        input  hz_stall, branch_taken_D, mdu_op_E, mdu_done,
        output mdu_start, mdu_abort, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, redirect_D
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Merges hazard
//   stalls, the Decode branch redirect and a multi-cycle MDU handshake into
//   the final enable/flush controls of the F/D, D/E and E/M registers.
//
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     bus (slave)  : request inputs and per-stage control outputs
//     mdu_timeout  : sticky flag, set when an MDU operation was aborted
//     stall_cnt    : saturating count of cycles with StallF=1
//
//   Parameters:
//     MDU_TIMEOUT  : BUSY cycles allowed before the MDU op is aborted (>= 2)
//     CNT_W        : width of stall_cnt
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  bus,
    output logic                  mdu_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int BW = $clog2(MDU_TIMEOUT);
    localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [BW-1:0] busy_cnt;

    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, flush_m;
    logic start, abort, redirect;
    logic front_eval;
    logic at_limit;

    assign at_limit = (busy_cnt == BUSY_LAST);

    // NOTE: every output gets a default before any branch so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        redirect   = 1'b0;
        front_eval = 1'b0;

        if (!rst_n) begin
            // Bubble everything while reset is held.
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (state == IDLE) begin
            if (bus.mdu_op_E) begin
                // Launch takes priority over hazard and branch this cycle.
                start   = 1'b1;
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else begin
                front_eval = 1'b1;
            end
        end else begin
            if (bus.mdu_done) begin
                // Completion wins over a coincident timeout.
                front_eval = 1'b1;
            end else if (at_limit) begin
                // Release the front and turn the mul/div into a bubble.
                abort   = 1'b1;
                flush_m = 1'b1;
            end else begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end
        end

        // Hazard beats branch: a stalled branch's operands are not yet valid.
        if (front_eval) begin
            if (bus.hz_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (bus.branch_taken_D) begin
                redirect = 1'b1;
                flush_d  = 1'b1;
            end
        end
    end

    assign bus.StallF     = stall_f;
    assign bus.StallD     = stall_d;
    assign bus.StallE     = stall_e;
    assign bus.FlushD     = flush_d;
    assign bus.FlushE     = flush_e;
    assign bus.FlushM     = flush_m;
    assign bus.mdu_start  = start;
    assign bus.mdu_abort  = abort;
    assign bus.redirect_D = redirect;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_cnt    <= '0;
            mdu_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mdu_op_E) begin
                        state    <= BUSY;
                        busy_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (bus.mdu_done) begin
                        state <= IDLE;
                    end else if (at_limit) begin
                        state       <= IDLE;
                        mdu_timeout <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (stall_f && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed bench. dut_a uses the default parameters; dut_b uses
//   MDU_TIMEOUT=4 and CNT_W=3 to reach the timeout and counter saturation.
//   Control vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,
//                          mdu_start,mdu_abort,redirect_D}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    logic clk;
    logic rst_n_a, rst_n_b;
    logic mdu_timeout_a, mdu_timeout_b;
    logic [31:0] stall_cnt_a;
    logic [2:0]  stall_cnt_b;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl_if bus_a ();
    pipeline_stall_ctrl_if bus_b ();

    pipeline_stall_ctrl dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .bus         (bus_a.slave),
        .mdu_timeout (mdu_timeout_a),
        .stall_cnt   (stall_cnt_a)
    );

    pipeline_stall_ctrl #(.MDU_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .bus         (bus_b.slave),
        .mdu_timeout (mdu_timeout_b),
        .stall_cnt   (stall_cnt_b)
    );

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.FlushD,
                    bus_a.FlushE, bus_a.FlushM, bus_a.mdu_start,
                    bus_a.mdu_abort, bus_a.redirect_D};
    assign ctl_b = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.FlushD,
                    bus_b.FlushE, bus_b.FlushM, bus_b.mdu_start,
                    bus_b.mdu_abort, bus_b.redirect_D};

    localparam logic [8:0] C_RST   = 9'b000_111_000;
    localparam logic [8:0] C_NONE  = 9'b000_000_000;
    localparam logic [8:0] C_HZ    = 9'b110_010_000;
    localparam logic [8:0] C_BR    = 9'b000_100_001;
    localparam logic [8:0] C_START = 9'b111_001_100;
    localparam logic [8:0] C_BUSY  = 9'b111_001_000;
    localparam logic [8:0] C_ABORT = 9'b000_001_010;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic op, input logic done, input logic hz,
                         input logic br);
        bus_a.mdu_op_E       = op;
        bus_a.mdu_done       = done;
        bus_a.hz_stall       = hz;
        bus_a.branch_taken_D = br;
    endtask

    task automatic set_b(input logic op, input logic done, input logic hz,
                         input logic br);
        bus_b.mdu_op_E       = op;
        bus_b.mdu_done       = done;
        bus_b.hz_stall       = hz;
        bus_b.branch_taken_D = br;
    endtask

    initial begin
        // ---------------- reset, all inputs high ----------------
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        set_a(1, 1, 1, 1);
        set_b(1, 1, 1, 1);
        #1;
        check("rst_ctl_a_t0", 32'(ctl_a), 32'(C_RST));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ctl_a", 32'(ctl_a), 32'(C_RST));
        end
        check("rst_ctl_b", 32'(ctl_b), 32'(C_RST));
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        #1;
        check("rst_stall_cnt_a", stall_cnt_a, 32'd0);
        check("rst_timeout_a", 32'(mdu_timeout_a), 32'd0);
        check("rst_stall_cnt_b", 32'(stall_cnt_b), 32'd0);
        check("idle_ctl_a", 32'(ctl_a), 32'(C_NONE));

        // ---------------- load-use plus branch (A) ----------------
        tick();
        set_a(0, 0, 1, 1);
        #1;
        check("hz_br_ctl", 32'(ctl_a), 32'(C_HZ));
        tick();
        set_a(0, 0, 0, 1);
        #1;
        check("br_ctl", 32'(ctl_a), 32'(C_BR));
        check("hz_stall_cnt", stall_cnt_a, 32'd1);
        tick();

        // ---------------- MDU, 5-cycle latency (A) ----------------
        set_a(1, 0, 0, 0);
        #1;
        check("mdu5_start", 32'(ctl_a), 32'(C_START));
        for (int i = 1; i <= 4; i++) begin
            tick();
            #1;
            check("mdu5_busy", 32'(ctl_a), 32'(C_BUSY));
        end
        tick();
        set_a(1, 1, 0, 0);
        #1;
        check("mdu5_done", 32'(ctl_a), 32'(C_NONE));
        tick();
        set_a(0, 0, 0, 0);
        #1;
        // 1 from the load-use cycle plus 5 MDU stall cycles.
        check("mdu5_stall_cnt", stall_cnt_a, 32'd6);
        check("mdu5_idle", 32'(ctl_a), 32'(C_NONE));

        // ---------------- MDU with simultaneous hazard (A) ----------------
        tick();
        set_a(1, 0, 1, 0);
        #1;
        check("mduhz_start", 32'(ctl_a), 32'(C_START));
        tick();
        set_a(1, 1, 1, 0);
        #1;
        check("mduhz_done", 32'(ctl_a), 32'(C_HZ));
        tick();
        set_a(0, 1, 0, 0);
        #1;
        check("mduhz_stall_cnt", stall_cnt_a, 32'd8);
        // mdu_done while IDLE has no effect.
        check("idle_done_ctl", 32'(ctl_a), 32'(C_NONE));
        tick();
        set_a(0, 0, 0, 0);
        #1;
        check("idle_done_cnt", stall_cnt_a, 32'd8);
        check("a_no_timeout", 32'(mdu_timeout_a), 32'd0);

        // ---------------- timeout, MDU_TIMEOUT=4 (B) ----------------
        set_b(1, 0, 0, 0);
        #1;
        check("to_start", 32'(ctl_b), 32'(C_START));
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1;
            check("to_busy", 32'(ctl_b), 32'(C_BUSY));
        end
        tick();
        #1;
        check("to_abort", 32'(ctl_b), 32'(C_ABORT));
        check("to_flag_pre", 32'(mdu_timeout_b), 32'd0);
        tick();
        set_b(0, 1, 0, 0);
        #1;
        check("to_flag", 32'(mdu_timeout_b), 32'd1);
        check("to_late_done", 32'(ctl_b), 32'(C_NONE));
        check("to_stall_cnt", 32'(stall_cnt_b), 32'd4);

        // Second op re-arms and completes exactly at the limit.
        tick();
        set_b(1, 0, 0, 0);
        #1;
        check("rearm_start", 32'(ctl_b), 32'(C_START));
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1;
            check("rearm_busy", 32'(ctl_b), 32'(C_BUSY));
        end
        tick();
        set_b(1, 1, 0, 0);
        #1;
        check("rearm_done_limit", 32'(ctl_b), 32'(C_NONE));
        tick();
        set_b(0, 0, 0, 0);
        #1;
        // 4 + 4 stall cycles saturate a 3-bit counter at 7.
        check("sat_stall_cnt", 32'(stall_cnt_b), 32'd7);
        check("rearm_flag_sticky", 32'(mdu_timeout_b), 32'd1);

        // ---------------- reset clears sticky flag (B) ----------------
        rst_n_b = 1'b0;
        #1;
        check("rstb_ctl", 32'(ctl_b), 32'(C_RST));
        tick();
        rst_n_b = 1'b1;
        #1;
        check("rstb_flag", 32'(mdu_timeout_b), 32'd0);
        check("rstb_cnt", 32'(stall_cnt_b), 32'd0);

        // Done exactly in the 4th BUSY cycle: no abort, no flag.
        set_b(1, 0, 0, 0);
        #1;
        check("lim_start", 32'(ctl_b), 32'(C_START));
        for (int i = 1; i <= 3; i++) begin
            tick();
        end
        tick();
        set_b(1, 1, 0, 0);
        #1;
        check("lim_done_no_abort", 32'(ctl_b), 32'(C_NONE));
        tick();
        set_b(0, 0, 0, 0);
        #1;
        check("lim_flag", 32'(mdu_timeout_b), 32'd0);
        check("lim_stall_cnt", 32'(stall_cnt_b), 32'd4);

        // ---------------- reset in BUSY cycle 2 (B) ----------------
        set_b(1, 0, 0, 0);
        tick();
        tick();
        rst_n_b = 1'b0;
        #1;
        check("midrst_ctl", 32'(ctl_b), 32'(C_RST));
        tick();
        rst_n_b = 1'b1;
        #1;
        // mdu_op_E still high: a fresh start pulse proves the FSM is IDLE.
        check("midrst_idle", 32'(ctl_b), 32'(C_START));
        check("midrst_cnt", 32'(stall_cnt_b), 32'd0);
        check("midrst_flag", 32'(mdu_timeout_b), 32'd0);
        set_b(0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
